radio_serializer: RTL and testbench
===================================

# radio_serializer

Parametrised serialiser for radio front-end samples, the successor to the fixed 8-bit, free-running serial output stage. It accepts one packed word of I/Q samples from NUM_RADIOS radios per SAMPLE_STB and shifts it out LSB-first on DATA_OUT, one bit per SYS_CLK. A framing SYNC_WORD is inserted every FRAME_LEN data words so the receiver can align. A one-deep holding buffer absorbs strobe jitter, and a sticky overflow flag reports dropped samples. Everything runs on the single fast serial clock.

## Interface
- NUM_RADIOS, 2, number of radio channels packed per word (≥1)
- SAMPLE_BITS, 2, bits per I or Q component (≥1)
- W (derived, not overridable), NUM_RADIOS*2*SAMPLE_BITS, word width
- FRAME_LEN, 1023, data words between sync words (≥1)
- SYNC_WORD, W'hA5 pattern truncated/zero-extended to W, framing pattern
- SYS_CLK  in  1  serial bit clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- ENABLE  in  1  stream enable
- SAMPLE_STB  in  1  one-cycle strobe: SAMPLE_IN valid
- SAMPLE_IN  in  W  packed word, radio 0 in MSBs, ordered {R0_I,R0_Q,R1_I,R1_Q,...}
- CLR_FLAGS  in  1  clears OVERFLOW
- DATA_OUT  out  1  registered serial data, LSB of each word first
- SYNC  out  1  high during bit 0 of each sync word
- WORD_START  out  1  high during bit 0 of each data word
- BUSY  out  1  shifter active (not IDLE)
- OVERFLOW  out  1  sticky: a sample was dropped

## Operation
- Holding buffer HOLD (W bits + valid). SAMPLE_STB with ENABLE=1 writes HOLD if empty, or if HOLD is being consumed on that same edge (no overflow). Otherwise the sample is dropped and OVERFLOW is set. Strobes with ENABLE=0 are ignored.
- Shift register SR (W bits), bit counter BC (0..W-1), frame counter FC (0..FRAME_LEN-1).
- FSM states: IDLE, SYNC_TX, DATA_TX.
- IDLE: DATA_OUT=0. If HOLD valid and ENABLE: if FC==0, load SR=SYNC_WORD and go to SYNC_TX; else load SR=HOLD, clear valid, and go to DATA_TX.
- SYNC_TX: shift for W cycles. At BC==W-1, if HOLD valid, load HOLD into SR and go to DATA_TX back-to-back. Otherwise go to IDLE with FC kept at 0 and the pending flag set, so the next load goes straight to DATA_TX without a second sync.
- DATA_TX: at BC==W-1, FC increments, wrapping FRAME_LEN-1→0. The next word is chosen as from IDLE: sync if FC is now 0, else HOLD if valid, else IDLE.
- ENABLE falling: the current word (sync or data) completes. The FSM then returns to IDLE, FC resets to 0, and HOLD is cleared. Re-enable always starts with a sync word.
- Simultaneous CLR_FLAGS and a new overflow: OVERFLOW stays 1 (set wins).
- BC wraps W-1→0. All counters are sized with $clog2 (minimum width 1).

## Timing
- Reset values: DATA_OUT=0, SYNC=0, WORD_START=0, BUSY=0, OVERFLOW=0, FSM=IDLE, BC=0, FC=0, HOLD empty. RST mid-word aborts the word immediately; outputs reach their reset values after that edge.
- Latency: strobe sampled at edge E0 → HOLD valid. Edge E1 loads SR. DATA_OUT carries bit 0 in the cycle after E1.
  - If a sync word is due, data bit 0 appears W cycles later.
- Words are contiguous: no idle bit between consecutive words when HOLD is valid at BC==W-1.
- SYNC and WORD_START are registered and aligned with the DATA_OUT bit they mark.
- Sustainable strobe period: ≥ ceil(W*(FRAME_LEN+1)/FRAME_LEN) cycles; faster strobing eventually sets OVERFLOW.

## Test plan
- Defaults (W=8, FRAME_LEN=4), strobe every 10 cycles with words 0x01,0x02,... → DATA_OUT stream is SYNC 0xA5, then 4 words LSB-first, then SYNC again. SYNC and WORD_START pulses land on the correct bits. OVERFLOW=0.
- Strobe every 8 cycles, FRAME_LEN=4 → OVERFLOW set within 40 words. The dropped word is absent from the stream. CLR_FLAGS clears OVERFLOW on the next edge.
- Strobe on the same cycle the shifter consumes HOLD → no overflow, and both words are transmitted in order.
- ENABLE low mid-data-word → that word finishes, BUSY=0, DATA_OUT=0. Re-enable plus strobe 0x3C → 0xA5 then 0x3C.
- RST asserted at BC=3 → next cycle DATA_OUT=0, BUSY=0. First word after reset is preceded by a sync word.
- NUM_RADIOS=4, SAMPLE_BITS=1, FRAME_LEN=1 → W=8. Sync inserted before every data word. Packing order is radio 0 in the MSBs.

Source files
------------

// File: rtl/radio_serializer.sv
// radio_serializer: takes one packed I/Q word per SAMPLE_STB and shifts it out LSB-first,
// inserting SYNC_WORD ahead of every FRAME_LEN data words, behind a one-deep holding buffer.
module radio_serializer #(
    parameter int NUM_RADIOS  = 2,
    parameter int SAMPLE_BITS = 2,
    parameter int FRAME_LEN   = 1023,
    parameter logic [NUM_RADIOS*2*SAMPLE_BITS-1:0] SYNC_WORD =
        (NUM_RADIOS*2*SAMPLE_BITS)'(8'hA5)
) (
    input  logic                                 SYS_CLK,
    input  logic                                 RST,
    input  logic                                 ENABLE,
    input  logic                                 SAMPLE_STB,
    input  logic [NUM_RADIOS*2*SAMPLE_BITS-1:0]  SAMPLE_IN,
    input  logic                                 CLR_FLAGS,
    output logic                                 DATA_OUT,
    output logic                                 SYNC,
    output logic                                 WORD_START,
    output logic                                 BUSY,
    output logic                                 OVERFLOW
);

    localparam int W    = NUM_RADIOS * 2 * SAMPLE_BITS;
    localparam int BC_W = (W > 1) ? $clog2(W) : 1;
    localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(W - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC_TX = 2'd1,
        DATA_TX = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [W-1:0]      sr_r;
    logic [BC_W-1:0]   bc_r;
    logic [FC_W-1:0]   fc_r;
    logic [FC_W-1:0]   fc_s;
    logic [FC_W-1:0]   fc_wrap_s;
    logic              pending_r;
    logic              pending_s;
    logic              stop_r;
    logic              stop_s;
    logic              stopping_s;
    logic [W-1:0]      hold_r;
    logic              hold_valid_r;
    logic              load_sync_s;
    logic              load_data_s;
    logic              shift_s;
    logic              clear_hold_s;
    logic              accept_s;
    logic              hold_free_s;
    logic              ovf_set_s;
    logic              data_out_r;
    logic              sync_r;
    logic              word_start_r;
    logic              busy_r;
    logic              overflow_r;

    function automatic logic [FC_W-1:0] frame_next(input logic [FC_W-1:0] fc);
        if (fc == FC_LAST) begin
            frame_next = {FC_W{1'b0}};
        end else begin
            frame_next = fc + FC_W'(1'b1);
        end
    endfunction

    // Next-state decode: word boundaries pick sync, held data or idle.
    always_comb begin
        state_s      = state_r;
        fc_s         = fc_r;
        pending_s    = pending_r;
        load_sync_s  = 1'b0;
        load_data_s  = 1'b0;
        shift_s      = 1'b0;
        clear_hold_s = 1'b0;
        fc_wrap_s    = frame_next(fc_r);
        stopping_s   = stop_r | ~ENABLE;
        if ((state_r != IDLE) && !ENABLE) begin
            stop_s = 1'b1;
        end else begin
            stop_s = stop_r;
        end
        case (state_r)
            IDLE: begin
                if (!ENABLE) begin
                    fc_s         = {FC_W{1'b0}};
                    pending_s    = 1'b0;
                    clear_hold_s = 1'b1;
                end else if (hold_valid_r) begin
                    if ((fc_r == {FC_W{1'b0}}) && !pending_r) begin
                        load_sync_s = 1'b1;
                        state_s     = SYNC_TX;
                    end else begin
                        load_data_s = 1'b1;
                        pending_s   = 1'b0;
                        state_s     = DATA_TX;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SYNC_TX: begin
                if (bc_r != BC_LAST) begin
                    shift_s = 1'b1;
                end else if (stopping_s) begin
                    state_s      = IDLE;
                    fc_s         = {FC_W{1'b0}};
                    pending_s    = 1'b0;
                    stop_s       = 1'b0;
                    clear_hold_s = 1'b1;
                end else if (hold_valid_r) begin
                    load_data_s = 1'b1;
                    state_s     = DATA_TX;
                end else begin
                    // Sync already sent for this frame: next data goes out without another one.
                    state_s   = IDLE;
                    pending_s = 1'b1;
                end
            end
            DATA_TX: begin
                if (bc_r != BC_LAST) begin
                    shift_s = 1'b1;
                end else if (stopping_s) begin
                    state_s      = IDLE;
                    fc_s         = {FC_W{1'b0}};
                    pending_s    = 1'b0;
                    stop_s       = 1'b0;
                    clear_hold_s = 1'b1;
                end else begin
                    fc_s = fc_wrap_s;
                    if (fc_wrap_s == {FC_W{1'b0}}) begin
                        load_sync_s = 1'b1;
                        state_s     = SYNC_TX;
                    end else if (hold_valid_r) begin
                        load_data_s = 1'b1;
                        pending_s   = 1'b0;
                        state_s     = DATA_TX;
                    end else begin
                        state_s = IDLE;
                    end
                end
            end
            default: begin
                state_s      = IDLE;
                fc_s         = {FC_W{1'b0}};
                pending_s    = 1'b0;
                stop_s       = 1'b0;
                clear_hold_s = 1'b1;
            end
        endcase
    end

    // Holding-buffer write arbitration; a slot freed on this edge may be refilled on it.
    always_comb begin
        accept_s    = SAMPLE_STB & ENABLE;
        hold_free_s = ~hold_valid_r | load_data_s | clear_hold_s;
        ovf_set_s   = accept_s & ~hold_free_s;
    end

    // Control state: FSM, frame counter, pending-sync and stop request.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            fc_r      <= {FC_W{1'b0}};
            pending_r <= 1'b0;
            stop_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            fc_r      <= fc_s;
            pending_r <= pending_s;
            stop_r    <= stop_s;
            busy_r    <= (state_s != IDLE);
        end
    end

    // Shifter and registered serial outputs.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            sr_r         <= {W{1'b0}};
            bc_r         <= {BC_W{1'b0}};
            data_out_r   <= 1'b0;
            sync_r       <= 1'b0;
            word_start_r <= 1'b0;
        end else if (load_sync_s) begin
            sr_r         <= SYNC_WORD >> 1;
            bc_r         <= {BC_W{1'b0}};
            data_out_r   <= SYNC_WORD[0];
            sync_r       <= 1'b1;
            word_start_r <= 1'b0;
        end else if (load_data_s) begin
            sr_r         <= hold_r >> 1;
            bc_r         <= {BC_W{1'b0}};
            data_out_r   <= hold_r[0];
            sync_r       <= 1'b0;
            word_start_r <= 1'b1;
        end else if (shift_s) begin
            sr_r         <= sr_r >> 1;
            bc_r         <= bc_r + BC_W'(1'b1);
            data_out_r   <= sr_r[0];
            sync_r       <= 1'b0;
            word_start_r <= 1'b0;
        end else begin
            sr_r         <= sr_r;
            bc_r         <= {BC_W{1'b0}};
            data_out_r   <= 1'b0;
            sync_r       <= 1'b0;
            word_start_r <= 1'b0;
        end
    end

    // Holding buffer and sticky overflow; a new drop beats CLR_FLAGS.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            hold_r       <= {W{1'b0}};
            hold_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (accept_s && hold_free_s) begin
                hold_r       <= SAMPLE_IN;
                hold_valid_r <= 1'b1;
            end else if (load_data_s || clear_hold_s) begin
                hold_valid_r <= 1'b0;
            end else begin
                hold_valid_r <= hold_valid_r;
            end
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (CLR_FLAGS) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign DATA_OUT   = data_out_r;
    assign SYNC       = sync_r;
    assign WORD_START = word_start_r;
    assign BUSY       = busy_r;
    assign OVERFLOW   = overflow_r;

endmodule

// File: tb/tb_radio_serializer.sv
// Bench for radio_serializer: two instances (W=8/FRAME_LEN=4 and 4x1-bit radios/FRAME_LEN=1)
// checked each cycle against a word-level stream model, plus directed stream checks.
module tb_radio_serializer;

    logic       clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [1:0] en  = 2'b00;
    logic [1:0] stb = 2'b00;
    logic [1:0] clr = 2'b00;
    logic [7:0] din [2];
    wire  [1:0] dout, syn, wst, bsy, ovf;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    radio_serializer #(.FRAME_LEN(4)) dut_a (
        .SYS_CLK(clk), .RST(rst[0]), .ENABLE(en[0]), .SAMPLE_STB(stb[0]),
        .SAMPLE_IN(din[0]), .CLR_FLAGS(clr[0]), .DATA_OUT(dout[0]), .SYNC(syn[0]),
        .WORD_START(wst[0]), .BUSY(bsy[0]), .OVERFLOW(ovf[0])
    );

    radio_serializer #(.NUM_RADIOS(4), .SAMPLE_BITS(1), .FRAME_LEN(1)) dut_b (
        .SYS_CLK(clk), .RST(rst[1]), .ENABLE(en[1]), .SAMPLE_STB(stb[1]),
        .SAMPLE_IN(din[1]), .CLR_FLAGS(clr[1]), .DATA_OUT(dout[1]), .SYNC(syn[1]),
        .WORD_START(wst[1]), .BUSY(bsy[1]), .OVERFLOW(ovf[1])
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: current word as a bit count plus remaining bits, hold slot, frame count.
    bit [7:0] m_cw [2];
    int       m_left [2];
    int       m_kind [2];   // 0 none, 1 sync, 2 data
    int       m_fc [2];
    bit       m_pend [2], m_stop [2], m_hv [2], m_ovf [2];
    bit [7:0] m_hw [2];
    bit       e_do [2], e_sync [2], e_ws [2], e_busy [2], e_ovf [2];
    bit       mb, mclr, msd, macc;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_cw[i] = 8'h00; m_left[i] = 0; m_kind[i] = 0; m_fc[i] = 0;
                m_pend[i] = 1'b0; m_stop[i] = 1'b0; m_hv[i] = 1'b0; m_hw[i] = 8'h00; m_ovf[i] = 1'b0;
            end else begin
                mb   = (m_left[i] > 0);
                mclr = 1'b0;
                if (mb && !en[i]) m_stop[i] = 1'b1;
                if (mb) begin
                    m_cw[i]   = m_cw[i] >> 1;
                    m_left[i] = m_left[i] - 1;
                end
                if (m_left[i] == 0) begin
                    if (mb && m_stop[i]) begin
                        m_fc[i] = 0; m_pend[i] = 1'b0; m_stop[i] = 1'b0; mclr = 1'b1; m_kind[i] = 0;
                    end else if (!mb && !en[i]) begin
                        m_fc[i] = 0; m_pend[i] = 1'b0; mclr = 1'b1;
                    end else begin
                        msd = 1'b0;
                        if (mb && m_kind[i] == 2) begin
                            m_fc[i] = (m_fc[i] + 1) % ((i == 0) ? 4 : 1);
                            msd = (m_fc[i] == 0);
                        end else if (!mb) begin
                            msd = (m_fc[i] == 0) && !m_pend[i] && m_hv[i];
                        end
                        if (msd) begin
                            m_cw[i] = 8'hA5; m_left[i] = 8; m_kind[i] = 1;
                        end else if (m_hv[i]) begin
                            m_cw[i] = m_hw[i]; m_left[i] = 8; m_kind[i] = 2;
                            m_hv[i] = 1'b0; m_pend[i] = 1'b0;
                        end else begin
                            if (mb && m_kind[i] == 1) m_pend[i] = 1'b1;
                            m_kind[i] = 0;
                        end
                    end
                end
                if (mclr) m_hv[i] = 1'b0;
                macc = stb[i] && en[i];
                if (macc && m_hv[i]) begin
                    m_ovf[i] = 1'b1;
                end else begin
                    if (macc) begin
                        m_hv[i] = 1'b1; m_hw[i] = din[i];
                    end
                    if (clr[i]) m_ovf[i] = 1'b0;
                end
            end
            e_busy[i] = (m_left[i] > 0);
            e_do[i]   = (m_left[i] > 0) ? m_cw[i][0] : 1'b0;
            e_sync[i] = (m_kind[i] == 1) && (m_left[i] == 8);
            e_ws[i]   = (m_kind[i] == 2) && (m_left[i] == 8);
            e_ovf[i]  = m_ovf[i];
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                check_val($sformatf("data_out%0d", i),   32'(dout[i]), 32'(e_do[i]));
                check_val($sformatf("sync%0d", i),       32'(syn[i]),  32'(e_sync[i]));
                check_val($sformatf("word_start%0d", i), 32'(wst[i]),  32'(e_ws[i]));
                check_val($sformatf("busy%0d", i),       32'(bsy[i]),  32'(e_busy[i]));
                check_val($sformatf("overflow%0d", i),   32'(ovf[i]),  32'(e_ovf[i]));
            end
        end
    end

    // Word capture from the DUT serial stream: {is_sync, word}.
    logic [8:0] capq0 [$];
    logic [8:0] capq1 [$];
    logic [7:0] cap_w [2];
    bit         cap_k [2];
    int         cap_n [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bsy[i] !== 1'b1) begin
                cap_n[i] = 0;
            end else if (syn[i] || wst[i]) begin
                cap_w[i] = {7'b0000000, dout[i]};
                cap_k[i] = syn[i];
                cap_n[i] = 1;
            end else if (cap_n[i] > 0 && cap_n[i] < 8) begin
                cap_w[i][cap_n[i]] = dout[i];
                cap_n[i] = cap_n[i] + 1;
            end
            if (cap_n[i] == 8) begin
                if (i == 0) capq0.push_back({cap_k[i], cap_w[i]});
                else        capq1.push_back({cap_k[i], cap_w[i]});
                cap_n[i] = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input int i, input logic [7:0] w);
        stb[i] = 1'b1;
        din[i] = w;
        @(negedge clk);
        stb[i] = 1'b0;
    endtask

    task automatic wait_quiet(input int i);
        int q, n;
        q = 0; n = 0;
        while (q < 12 && n < 600) begin
            @(negedge clk);
            n++;
            if (bsy[i]) q = 0; else q++;
        end
        if (q < 12) check_val("quiet_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_mark(input int i, input bit ws_only);
        int n;
        n = 0;
        while (!(wst[i] || (!ws_only && syn[i])) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_val("mark_timeout", 32'h0, 32'h1);
    endtask

    task automatic check_cap(input int i, input int k, input logic [8:0] exp);
        logic [31:0] obs;
        obs = 32'hDEAD;
        if (i == 0 && k < capq0.size()) obs = 32'(capq0[k]);
        if (i == 1 && k < capq1.size()) obs = 32'(capq1[k]);
        check_val($sformatf("stream%0d_word%0d", i, k), obs, 32'(exp));
    endtask

    initial begin
        logic [8:0] exp1 [8];
        logic [7:0] bw [3];
        logic [7:0] wx, wy, wz, wv, tw;
        int rate;
        din[0] = 8'h00;
        din[1] = 8'h00;
        tick(3);
        chk_on = 1'b1;
        check_val("reset_data_out",   32'(dout[0]), 32'h0);
        check_val("reset_sync",       32'(syn[0]),  32'h0);
        check_val("reset_word_start", 32'(wst[0]),  32'h0);
        check_val("reset_busy",       32'(bsy[0]),  32'h0);
        check_val("reset_overflow",   32'(ovf[0]),  32'h0);
        rst = 2'b00;
        en  = 2'b11;
        tick(2);

        // Framing at a relaxed strobe rate.
        for (int k = 1; k <= 6; k++) begin
            strobe(0, 8'(k));
            tick(9);
        end
        wait_quiet(0);
        exp1[0] = 9'h1A5; exp1[1] = 9'h001; exp1[2] = 9'h002; exp1[3] = 9'h003;
        exp1[4] = 9'h004; exp1[5] = 9'h1A5; exp1[6] = 9'h005; exp1[7] = 9'h006;
        for (int k = 0; k < 8; k++) check_cap(0, k, exp1[k]);
        check_val("relaxed_overflow", 32'(ovf[0]), 32'h0);

        // Strobing every W cycles cannot keep up once syncs are inserted.
        for (int k = 0; k < 40; k++) begin
            strobe(0, 8'($urandom));
            tick(7);
        end
        wait_quiet(0);
        check_val("fast_overflow", 32'(ovf[0]), 32'h1);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        check_val("clr_overflow", 32'(ovf[0]), 32'h0);

        // Strobe on the edge the sync word ends and HOLD is consumed.
        rst[0] = 1'b1;
        tick(2);
        rst[0] = 1'b0;
        capq0.delete();
        wx = 8'h3A; wy = 8'hC6;
        strobe(0, wx);
        tick(8);
        strobe(0, wy);
        wait_quiet(0);
        check_cap(0, 0, 9'h1A5);
        check_cap(0, 1, {1'b0, wx});
        check_cap(0, 2, {1'b0, wy});
        check_val("consume_overflow", 32'(ovf[0]), 32'h0);

        // ENABLE falls mid data word: word completes, then idle; re-enable restarts with sync.
        capq0.delete();
        wz = 8'h96;
        strobe(0, wz);
        wait_mark(0, 1'b1);
        tick(2);
        en[0] = 1'b0;
        tick(14);
        check_val("disable_busy", 32'(bsy[0]), 32'h0);
        check_val("disable_data", 32'(dout[0]), 32'h0);
        check_cap(0, 0, {1'b0, wz});
        en[0] = 1'b1;
        capq0.delete();
        strobe(0, 8'h3C);
        wait_quiet(0);
        check_cap(0, 0, 9'h1A5);
        check_cap(0, 1, 9'h03C);

        // Reset while bit 3 is on the line.
        strobe(0, 8'h5A);
        wait_mark(0, 1'b0);
        tick(3);
        rst[0] = 1'b1;
        @(negedge clk);
        check_val("midword_rst_data", 32'(dout[0]), 32'h0);
        check_val("midword_rst_busy", 32'(bsy[0]), 32'h0);
        rst[0] = 1'b0;
        capq0.delete();
        wv = 8'h71;
        strobe(0, wv);
        wait_quiet(0);
        check_cap(0, 0, 9'h1A5);
        check_cap(0, 1, {1'b0, wv});

        // Four 1-bit radios, FRAME_LEN=1: sync around every data word, radio 0 in MSBs.
        capq1.delete();
        for (int k = 0; k < 3; k++) begin
            tw = 8'h00;
            for (int r = 0; r < 4; r++) begin
                tw[7 - 2 * r] = 1'($urandom);
                tw[6 - 2 * r] = 1'($urandom);
            end
            if (k == 0) tw = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            bw[k] = tw;
            strobe(1, tw);
            tick(19);
        end
        wait_quiet(1);
        for (int k = 0; k < 3; k++) begin
            check_cap(1, 2 * k, 9'h1A5);
            check_cap(1, 2 * k + 1, {1'b0, bw[k]});
        end
        check_cap(1, 6, 9'h1A5);

        // Randomised traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            rate = ((c / 500) % 2 == 1) ? 14 : 6;
            for (int i = 0; i < 2; i++) begin
                stb[i] = ($urandom_range(0, 99) < rate);
                din[i] = 8'($urandom);
                clr[i] = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 199) == 0) en[i] = ~en[i];
                rst[i] = ($urandom_range(0, 499) == 0);
            end
            @(negedge clk);
        end
        stb = 2'b00;
        rst = 2'b00;
        tick(4);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
